// File: rtl/seven_seg_reader_if.sv
// Bus bundle for seven_seg_reader: multiplexed segment/digit-select inputs,
// synchronous clear, decoded digit state and update/error pulses.
interface seven_seg_reader_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    upd_valid;
  logic [2:0]              upd_idx;
  logic [3:0]              upd_hex;
  logic                    err;
  logic [7:0]              err_count;

  // Display driver / checker side
  modport master (
    output seg_in, dig_sel, clear,
    input  digits_out, digit_valid, upd_valid, upd_idx, upd_hex, err, err_count
  );

  // Reader side
  modport slave (
    input  seg_in, dig_sel, clear,
    output digits_out, digit_valid, upd_valid, upd_idx, upd_hex, err, err_count
  );
endinterface

// File: rtl/seven_seg_reader.sv
// seven_seg_reader: samples a multiplexed 7-segment bus, waits for a pattern to be
// stable for STABLE_CYCLES samples, then decodes the selected digit to a hex nibble.
// Optional build macro SEG_ACTIVE_LOW_EN: seg_in and dig_sel are active low and are
// inverted ahead of the sample register.
module seven_seg_reader #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  seven_seg_reader_if.slave   bus
);

  localparam int unsigned SAMP_W = NUM_DIGITS + 7;
  localparam int unsigned RUN_W  = 8;
  localparam int unsigned DIG_W  = 4 * NUM_DIGITS;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  localparam logic [0:0] ST_TRACK = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  logic [SAMP_W-1:0]     samp_in;
  logic [SAMP_W-1:0]     samp_q;
  logic [RUN_W-1:0]      run_q, run_d;
  logic [0:0]            state_q, state_d;
  logic [DIG_W-1:0]      digits_q, digits_d;
  logic [NUM_DIGITS-1:0] valid_q, valid_d;
  logic                  upd_valid_q, upd_valid_d;
  logic [2:0]            upd_idx_q, upd_idx_d;
  logic [3:0]            upd_hex_q, upd_hex_d;
  logic                  err_q, err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic [NUM_DIGITS-1:0] sel;
  logic [6:0]            pat;
  logic                  changed;
  logic                  accept;
  logic [4:0]            dec;

`ifdef SEG_ACTIVE_LOW_EN
  assign samp_in = ~{bus.dig_sel, bus.seg_in};
`else
  assign samp_in = {bus.dig_sel, bus.seg_in};
`endif

  // Glyph table lookup: {legal, nibble}
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1111110: decode = 5'h10;
      7'b0110000: decode = 5'h11;
      7'b1101101: decode = 5'h12;
      7'b1111001: decode = 5'h13;
      7'b0110011: decode = 5'h14;
      7'b1011011: decode = 5'h15;
      7'b1011111: decode = 5'h16;
      7'b1110000: decode = 5'h17;
      7'b1111111: decode = 5'h18;
      7'b1111011: decode = 5'h19;
      7'b1110111: decode = 5'h1A;
      7'b0011111: decode = 5'h1B;
      7'b1001110: decode = 5'h1C;
      7'b0111101: decode = 5'h1D;
      7'b1001111: decode = 5'h1E;
      7'b1000111: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  assign sel     = samp_q[SAMP_W-1:7];
  assign pat     = samp_q[6:0];
  assign changed = (samp_in != samp_q);
  assign accept  = (state_q == ST_TRACK) && (run_q == RUN_MAX);
  assign dec     = decode(pat);

  // Run length of identical samples (counting the newest), saturating at STABLE_CYCLES
  always_comb begin
    run_d = run_q;
    if (changed) begin
      run_d = RUN_W'(1);
    end else if (run_q < RUN_MAX) begin
      run_d = run_q + RUN_W'(1);
    end
  end

  // Next state and registered-output next values
  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    valid_d     = valid_q;
    upd_valid_d = 1'b0;
    upd_idx_d   = upd_idx_q;
    upd_hex_d   = upd_hex_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;

    // A change always restarts tracking, even on the acceptance edge
    if (changed) begin
      state_d = ST_TRACK;
    end else if (accept) begin
      state_d = ST_DONE;
    end

    if (bus.clear) begin
      valid_d   = '0;
      err_cnt_d = '0;
    end else if (accept && $onehot(sel)) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (sel[i]) begin
          if (dec[4]) begin
            digits_d[4*i +: 4] = dec[3:0];
            valid_d[i]         = 1'b1;
            upd_valid_d        = 1'b1;
            upd_idx_d          = 3'(i);
            upd_hex_d          = dec[3:0];
          end else begin
            valid_d[i] = 1'b0;
            if (pat != 7'd0) begin
              err_d = 1'b1;
              if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
              end
            end
          end
        end
      end
    end
  end

  // Sample register, run counter, FSM state and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q      <= '0;
      run_q       <= '0;
      state_q     <= ST_TRACK;
      digits_q    <= '0;
      valid_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_hex_q   <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      samp_q      <= samp_in;
      run_q       <= run_d;
      state_q     <= state_d;
      digits_q    <= digits_d;
      valid_q     <= valid_d;
      upd_valid_q <= upd_valid_d;
      upd_idx_q   <= upd_idx_d;
      upd_hex_q   <= upd_hex_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.digits_out  = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_idx     = upd_idx_q;
  assign bus.upd_hex     = upd_hex_q;
  assign bus.err         = err_q;
  assign bus.err_count   = err_cnt_q;

endmodule
